// File: rtl/pyramid_stage_fifo_pkg.sv
// Shared constants and helpers for the pyramid inter-stage FIFO.
// Pointers carry one extra wrap bit beyond the RAM address.
package pyramid_stage_fifo_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_DEPTH        = 512;
  localparam int DEF_AFULL_MARGIN = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pyramid_stage_fifo_if.sv
// Handshake and status bundle between the down sampler, the FIFO and the up sampler.
// The FIFO is the slave; the surrounding pipeline (or bench) is the master.
interface pyramid_stage_fifo_if
  import pyramid_stage_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CNT_W = ptr_w(DEPTH);

  logic              valid;
  logic [DATA_W-1:0] din;
  logic              rd_en_down;
  logic              rd_en_up;
  logic [DATA_W-1:0] dout;
  logic              valid_out;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output valid, din, rd_en_up,
    input  rd_en_down, dout, valid_out, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  valid, din, rd_en_up,
    output rd_en_down, dout, valid_out, empty, full, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/pyramid_stage_fifo_ram.sv
// Simple dual-port storage: synchronous write, read either registered (standard)
// or combinational (first-word-fall-through).
module pyramid_fifo_ram
  import pyramid_stage_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FWFT   = 0
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_p1;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q_p1 <= mem[raddr];
  end

  assign rdata = (FWFT != 0) ? mem[raddr] : q_p1;

endmodule

// File: rtl/pyramid_stage_fifo.sv
// Pyramid inter-stage FIFO: down sampler writes, up sampler reads.
// All status flags are registered from the next-state pointers.
module pyramid_stage_fifo
  import pyramid_stage_fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_MARGIN = DEF_AFULL_MARGIN,
  parameter int FWFT         = 0
) (
  input logic                 clk,
  input logic                 rst,
  pyramid_stage_fifo_if.slave fifo
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_MARGIN);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [PTR_W-1:0]  count_r;
  logic              wr_acc, rd_acc;
  logic              empty_r, full_r, afull_r, rd_en_down_r;
  logic              ovf_r, udf_r, vld_p1, dout_live;
  logic [DATA_W-1:0] ram_q;

  assign wr_acc = fifo.valid & ~full_r;
  assign rd_acc = fifo.rd_en_up & ~empty_r;

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{(PTR_W-1){1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{(PTR_W-1){1'b0}}, rd_acc};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // p0 -> p1: pointer and flag update
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_r      <= '0;
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      afull_r      <= 1'b0;
      rd_en_down_r <= 1'b1;
      ovf_r        <= 1'b0;
      udf_r        <= 1'b0;
      vld_p1       <= 1'b0;
      dout_live    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count_r      <= count_nxt;
      empty_r      <= (wr_ptr_nxt == rd_ptr_nxt);
      full_r       <= (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                      (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
      afull_r      <= (count_nxt >= AFULL_LVL);
      rd_en_down_r <= (count_nxt < AFULL_LVL);
      ovf_r        <= ovf_r | (fifo.valid & full_r);
      udf_r        <= udf_r | (fifo.rd_en_up & empty_r);
      vld_p1       <= rd_acc;
      dout_live    <= dout_live | rd_acc;
    end
  end

  pyramid_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .FWFT   (FWFT)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & rst),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (fifo.din),
    .re    (rd_acc & rst),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // Stale RAM output stays masked to zero after reset until the first read lands.
  assign fifo.dout        = (FWFT != 0) ? (empty_r ? '0 : ram_q)
                                        : (dout_live ? ram_q : '0);
  assign fifo.valid_out   = (FWFT != 0) ? ~empty_r : vld_p1;
  assign fifo.empty       = empty_r;
  assign fifo.full        = full_r;
  assign fifo.almost_full = afull_r;
  assign fifo.rd_en_down  = rd_en_down_r;
  assign fifo.count       = count_r;
  assign fifo.overflow    = ovf_r;
  assign fifo.underflow   = udf_r;

endmodule
